// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two
// valid/ready requesters; one operation in flight, result returned to its owner.
module alu_arbiter #(
    parameter int DATA_WIDTH    = 16,
    parameter int ALU_CON_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     req0Valid,
    output logic                     req0Ready,
    input  logic [DATA_WIDTH-1:0]    req0A,
    input  logic [DATA_WIDTH-1:0]    req0B,
    input  logic [ALU_CON_WIDTH-1:0] req0Con,
    input  logic                     req1Valid,
    output logic                     req1Ready,
    input  logic [DATA_WIDTH-1:0]    req1A,
    input  logic [DATA_WIDTH-1:0]    req1B,
    input  logic [ALU_CON_WIDTH-1:0] req1Con,
    output logic                     resp0Valid,
    input  logic                     resp0Ready,
    output logic                     resp1Valid,
    input  logic                     resp1Ready,
    output logic [DATA_WIDTH-1:0]    respData,
    output logic [DATA_WIDTH-1:0]    aluA,
    output logic [DATA_WIDTH-1:0]    aluB,
    output logic [ALU_CON_WIDTH-1:0] aluCon,
    input  logic [DATA_WIDTH-1:0]    aluResult,
    output logic                     busy
);

    // state | meaning
    // IDLE  | waiting for a request; combinational ready to the winner
    // EXEC  | operand registers drive the ALU; result captured at end of cycle
    // RESP  | result presented to owner until its respReady

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     ptr_q, ptr_d;
    logic                     owner_q, owner_d;
    logic [DATA_WIDTH-1:0]    opa_q, opa_d;
    logic [DATA_WIDTH-1:0]    opb_q, opb_d;
    logic [ALU_CON_WIDTH-1:0] con_q, con_d;
    logic [DATA_WIDTH-1:0]    res_q, res_d;

    logic winner;
    logic owner_ready;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            con_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            con_q   <= con_d;
            res_q   <= res_d;
        end
    end

    // Pointer only breaks ties; a lone valid requester always wins.
    assign winner      = (req0Valid && req1Valid) ? ptr_q : req1Valid;
    assign owner_ready = owner_q ? resp1Ready : resp0Ready;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        con_d      = con_q;
        res_d      = res_q;
        req0Ready  = 1'b0;
        req1Ready  = 1'b0;
        resp0Valid = 1'b0;
        resp1Valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0Valid || req1Valid) begin
                    req0Ready = ~winner;
                    req1Ready = winner;
                    state_d   = EXEC;
                    owner_d   = winner;
                    ptr_d     = ~winner;
                    opa_d     = winner ? req1A   : req0A;
                    opb_d     = winner ? req1B   : req0B;
                    con_d     = winner ? req1Con : req0Con;
                end
            end
            EXEC: begin
                res_d   = aluResult;
                state_d = RESP;
            end
            RESP: begin
                resp0Valid = ~owner_q;
                resp1Valid = owner_q;
                if (owner_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign aluA     = opa_q;
    assign aluB     = opb_q;
    assign aluCon   = con_q;
    assign respData = res_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level arbitration/ALU reference model.
module tb_alu_arbiter;

    localparam int DW = 16;
    localparam int CW = 3;

    logic          clk;
    logic          rstN;
    logic          req0Valid, req0Ready, req1Valid, req1Ready;
    logic [DW-1:0] req0A, req0B, req1A, req1B;
    logic [CW-1:0] req0Con, req1Con;
    logic          resp0Valid, resp0Ready, resp1Valid, resp1Ready;
    logic [DW-1:0] respData, aluA, aluB, aluResult;
    logic [CW-1:0] aluCon;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state: pending request per requester and the tie pointer
    bit            pend [2];
    logic [DW-1:0] pa   [2];
    logic [DW-1:0] pb   [2];
    logic [CW-1:0] pc   [2];
    int            ptr_m;

    alu_arbiter #(.DATA_WIDTH(DW), .ALU_CON_WIDTH(CW)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .req0Valid  (req0Valid),
        .req0Ready  (req0Ready),
        .req0A      (req0A),
        .req0B      (req0B),
        .req0Con    (req0Con),
        .req1Valid  (req1Valid),
        .req1Ready  (req1Ready),
        .req1A      (req1A),
        .req1B      (req1B),
        .req1Con    (req1Con),
        .resp0Valid (resp0Valid),
        .resp0Ready (resp0Ready),
        .resp1Valid (resp1Valid),
        .resp1Ready (resp1Ready),
        .respData   (respData),
        .aluA       (aluA),
        .aluB       (aluB),
        .aluCon     (aluCon),
        .aluResult  (aluResult),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [CW-1:0] c);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[3:0];
            3'd6:    return a >> b[3:0];
            default: return DW'($signed(a) >>> b[3:0]);
        endcase
    endfunction

    assign aluResult = alu_fn(aluA, aluB, aluCon);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        req0Valid = pend[0];
        req0A     = pa[0];
        req0B     = pb[0];
        req0Con   = pc[0];
        req1Valid = pend[1];
        req1A     = pa[1];
        req1B     = pb[1];
        req1Con   = pc[1];
    endtask

    // Called just after a rising edge with the DUT in IDLE; returns likewise.
    task automatic issue(input bit n0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                         input logic [CW-1:0] c0,
                         input bit n1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                         input logic [CW-1:0] c1, input int delay);
        int            w;
        logic [DW-1:0] ea, eb, exp;
        logic [CW-1:0] ec;
        if (n0 && !pend[0]) begin
            pend[0] = 1'b1; pa[0] = a0; pb[0] = b0; pc[0] = c0;
        end
        if (n1 && !pend[1]) begin
            pend[1] = 1'b1; pa[1] = a1; pb[1] = b1; pc[1] = c1;
        end
        drive_reqs();
        w   = (pend[0] && pend[1]) ? ptr_m : (pend[1] ? 1 : 0);
        ea  = pa[w];
        eb  = pb[w];
        ec  = pc[w];
        exp = alu_fn(ea, eb, ec);

        @(negedge clk);
        check_val("idle_busy", busy, 0);
        check_val("req0Ready_grant", req0Ready, 32'(w == 0));
        check_val("req1Ready_grant", req1Ready, 32'(w == 1));
        @(posedge clk); #1;
        pend[w] = 1'b0;
        ptr_m   = 1 - w;
        drive_reqs();

        @(negedge clk);
        check_val("exec_aluA", aluA, ea);
        check_val("exec_aluB", aluB, eb);
        check_val("exec_aluCon", aluCon, ec);
        check_val("exec_busy", busy, 1);
        check_val("exec_rsp_valids", {resp1Valid, resp0Valid}, 0);
        check_val("exec_req_readys", {req1Ready, req0Ready}, 0);
        @(posedge clk); #1;

        for (int i = 0; i <= delay; i++) begin
            // the non-owner always offers ready; it must be ignored
            if (w == 0) begin
                resp0Ready = (i == delay);
                resp1Ready = 1'b1;
            end else begin
                resp1Ready = (i == delay);
                resp0Ready = 1'b1;
            end
            @(negedge clk);
            check_val("resp0Valid", resp0Valid, 32'(w == 0));
            check_val("resp1Valid", resp1Valid, 32'(w == 1));
            check_val("respData", respData, exp);
            check_val("resp_req_readys", {req1Ready, req0Ready}, 0);
            @(posedge clk); #1;
        end
        resp0Ready = 1'b0;
        resp1Ready = 1'b0;
        check_val("back_idle_busy", busy, 0);
        check_val("back_idle_valids", {resp1Valid, resp0Valid}, 0);
        check_val("respData_hold", respData, exp);
        check_val("aluA_hold", aluA, ea);
    endtask

    initial begin
        rstN = 1'b0;
        resp0Ready = 1'b0;
        resp1Ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; pa[r] = '0; pb[r] = '0; pc[r] = '0;
        end
        ptr_m = 0;
        drive_reqs();

        #12;
        check_val("rst_busy", busy, 0);
        check_val("rst_valids", {resp1Valid, resp0Valid}, 0);
        check_val("rst_readys", {req1Ready, req0Ready}, 0);
        check_val("rst_respData", respData, 0);
        check_val("rst_aluA", aluA, 0);
        check_val("rst_aluCon", aluCon, 0);
        #10 rstN = 1'b1;
        @(posedge clk); #1;

        // contention from reset: 0,1,0,1
        issue(1, 16'h00F0, 16'h0F0F, 3'd2, 1, 16'h0009, 16'h0002, 3'd1, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(1, 16'h1234, 16'h0101, 3'd0, 1, 16'h0F00, 16'h00FF, 3'd3, 1);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // single op requester 0, then backpressured requester 1 with req0 held
        issue(1, 16'd5, 16'd3, 3'd0, 0, 0, 0, 0, 0);
        issue(1, 16'h0777, 16'h0001, 3'd1, 1, 16'd1, 16'd4, 3'd5, 5);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 2);

        // shifts and xor
        issue(1, 16'h8000, 16'd1, 3'd6, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 1, 16'h8000, 16'd1, 3'd7, 0);
        issue(1, 16'hAAAA, 16'hAAAA, 3'd4, 0, 0, 0, 0, 0);

        // reset during EXEC of 2+2
        pend[0] = 1'b1; pa[0] = 16'd2; pb[0] = 16'd2; pc[0] = 3'd0;
        drive_reqs();
        @(posedge clk); #1;
        pend[0] = 1'b0;
        drive_reqs();
        check_val("pre_rst_busy", busy, 1);
        #2 rstN = 1'b0;
        #1;
        check_val("midrst_valids", {resp1Valid, resp0Valid}, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_respData", respData, 0);
        @(posedge clk); #1;
        rstN  = 1'b1;
        ptr_m = 0;
        check_val("post_rst_respData", respData, 0);
        issue(1, 16'd3, 16'd4, 3'd0, 1, 16'd1, 16'd1, 3'd0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int t = 0; t < 150; t++) begin
            bit n0, n1;
            n0 = 1'($urandom_range(0, 1));
            n1 = 1'($urandom_range(0, 1));
            if (!n0 && !n1 && !pend[0] && !pend[1]) n0 = 1'b1;
            issue(n0, DW'($urandom), DW'($urandom), CW'($urandom),
                  n1, DW'($urandom), DW'($urandom), CW'($urandom),
                  int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
